uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, first-word fall-through receive FIFO.
// Stop-bit faults raise frame_err_o; a good frame that arrives while the FIFO is full raises overrun_o.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int CW       = $clog2(DATA_WIDTH + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [1:0]            sync_q;
  logic                  rx_sync;
  logic [BW-1:0]         baud_cnt, baud_cnt_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  push, frame_err_n, overrun_n;
  logic                  rd_do;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  assign rx_sync = sync_q[1];

  always_comb begin
    state_n     = state;
    baud_cnt_n  = baud_cnt;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    push        = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        if (rx_en_i && !rx_sync) state_n = START;
      end
      START: begin
        if (baud_cnt == BW'(HALF - 1)) begin
          baud_cnt_n = '0;
          state_n    = rx_sync ? IDLE : DATA;
        end else begin
          baud_cnt_n = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BW'(BAUD_DIV - 1)) begin
          baud_cnt_n = '0;
          shift_n    = {rx_sync, shift[DATA_WIDTH-1:1]};
          bit_cnt_n  = bit_cnt + CW'(1);
          if (bit_cnt == CW'(DATA_WIDTH - 1)) state_n = STOP;
        end else begin
          baud_cnt_n = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BW'(BAUD_DIV - 1)) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
          // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
          if (!rx_sync)                frame_err_n = 1'b1;
          else if (full_o && !rd_en_i) overrun_n   = 1'b1;
          else                         push        = 1'b1;
        end else begin
          baud_cnt_n = baud_cnt + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      sync_q      <= 2'b11;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_n;
      sync_q      <= {sync_q[0], rx_bit_i};
      baud_cnt    <= baud_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      frame_err_o <= frame_err_n;
      overrun_o   <= overrun_n;
    end
  end

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_do   = rd_en_i && !empty_o;
  assign dout_o  = mem[rd_ptr[AW-1:0]];
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (rd_do) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a queue-based FIFO model.
module tb_uart_rx;

  localparam int CLK_FREQ  = 2_100_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DW        = 8;
  localparam int DEPTH     = 16;
  localparam int BD        = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = BD / 2;
  // Edges from driving the start bit to the cycle where push / flag becomes visible.
  localparam int LAT       = 3 + HALF + (DW + 1) * BD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_en = 1'b0;
  logic          rx_bit = 1'b1;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          empty, full, busy, frame_err, overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_en_i(rx_en), .rx_bit_i(rx_bit), .rd_en_i(rd_en),
    .dout_o(dout), .empty_o(empty), .full_o(full), .busy_o(busy),
    .frame_err_o(frame_err), .overrun_o(overrun)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ferr_seen = 0, ovr_seen = 0, last_fall = 0, last_ferr = 0;
  logic prev_empty = 1'b1;

  logic [DW-1:0] q[$];
  int exp_ferr = 0, exp_ovr = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) begin
      ferr_seen <= ferr_seen + 1;
      last_ferr <= cyc;
    end
    if (overrun) ovr_seen <= ovr_seen + 1;
    if (prev_empty && !empty) last_fall <= cyc;
    prev_empty <= empty;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    #1;
    chk({tag, ".empty"}, empty, q.size() == 0);
    chk({tag, ".full"}, full, q.size() == DEPTH);
    if (q.size() > 0) chk({tag, ".dout"}, dout, q[0]);
    chk({tag, ".ferr"}, ferr_seen, exp_ferr);
    chk({tag, ".ovr"}, ovr_seen, exp_ovr);
  endtask

  task automatic model_frame(input logic [DW-1:0] d, input logic ok);
    if (!ok) exp_ferr++;
    else if (q.size() == DEPTH) exp_ovr++;
    else q.push_back(d);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    @(posedge clk);
    #1;
    t0 = cyc;
    rx_bit = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < DW; i++) begin
      #1 rx_bit = d[i];
      repeat (BD) @(posedge clk);
    end
    #1 rx_bit = stop;
    // A bad stop bit is released soon after mid-bit so the line is clearly idle afterwards.
    repeat (stop ? BD : HALF + 3) @(posedge clk);
    #1 rx_bit = 1'b1;
    repeat (stop ? BD : 2 * BD - HALF - 3) @(posedge clk);
  endtask

  task automatic pop_one();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".dout"}, dout, 0);
    chk({tag, ".empty"}, empty, 1);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".frame_err"}, frame_err, 0);
    chk({tag, ".overrun"}, overrun, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic ok;
    rx_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    chk("push_latency", last_fall - t0, LAT);
    check_model("a5");
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    check_model("3c");
    pop_one(); check_model("pop_a5");
    pop_one(); check_model("pop_3c");
    pop_one(); check_model("pop_empty");

    @(posedge clk);
    #1 rx_bit = 1'b0;
    repeat (HALF - 3) @(posedge clk);
    #1 rx_bit = 1'b1;
    @(negedge clk);
    chk("glitch_busy", busy, 1);
    repeat (2 * BD) @(posedge clk);
    check_model("glitch");
    chk("glitch_idle", busy, 0);

    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    chk("ferr_latency", last_ferr - t0, LAT);
    check_model("ferr");
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    check_model("81");
    pop_one(); check_model("pop_81");

    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(DW'(i), 1'b1);
      model_frame(DW'(i), 1'b1);
      check_model($sformatf("fill%0d", i));
    end

    fork
      send_frame(8'hEE, 1'b1);
      begin
        repeat (LAT) @(posedge clk);
        #1 rd_en = 1'b1;
        @(negedge clk);
        chk("full_rw.head", dout, q[0]);
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(8'hEE);
    check_model("full_rw");

    while (q.size() > 0) begin
      pop_one();
      check_model("drain");
    end

    rx_en = 1'b0;
    send_frame(8'h5A, 1'b1);
    check_model("rx_disabled");
    rx_en = 1'b1;

    send_frame(8'h33, 1'b1);
    model_frame(8'h33, 1'b1);
    check_model("pre_rst");
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (HALF + 4 * BD) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_data", busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    check_model("post_rst");
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1);
    check_model("7e");
    pop_one(); check_model("pop_7e");

    for (int n = 0; n < 12; n++) begin
      d  = DW'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, ok);
      model_frame(d, ok);
      check_model($sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) begin
        pop_one();
        check_model($sformatf("rand_pop%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
